turbo_rsc_encoder: RTL

Parametrised dual-stream recursive systematic convolutional (RSC) encoder for the LTE turbo encoder datapath. It encodes NCH bit streams in lock-step, typically the natural-order stream and the interleaved stream, over a run-time block length K. It then appends three trellis-termination tail beats per channel. It sits between the interleaver/bit source and the rate-matching stage, with valid/ready handshakes on both sides.

---
 rtl/turbo_enc_pkg.sv | 28 ++
 rtl/turbo_rsc_encoder_rsc_core.sv | 38 +++
 rtl/turbo_rsc_encoder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/turbo_enc_pkg.sv
// Shared types and trellis helpers for the
// LTE turbo RSC encoder.
package turbo_enc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_e;

  localparam int MEM      = 3;
  localparam int TAIL_LEN = 3;
  localparam int KMIN_DEF = 40;
  localparam int KMAX_DEF = 6144;

  // {s, par} for input bit c and state q = {q2,q1,q0}
  function automatic logic [1:0] rsc_step(
    input logic           c,
    input logic [MEM-1:0] q
  );
    logic fb;
    logic s;
    fb = q[1] ^ q[2];
    s  = c ^ fb;
    return {s, s ^ q[0] ^ q[2]};
  endfunction

endpackage

// File: rtl/turbo_rsc_encoder_rsc_core.sv
// One constituent RSC encoder: trellis memory
// plus feedback and parity logic.
module rsc_core
  import turbo_enc_pkg::*;
(
  input  logic           clk,
  input  logic           aclr_n,
  input  logic           clr,
  input  logic           step,
  input  logic           tail,
  input  logic           c,
  output logic           sys,
  output logic           par,
  output logic [MEM-1:0] q
);

  logic fb;
  logic c_eff;
  logic s;

  // tail beats feed back fb so the register drains to zero
  assign fb    = q[1] ^ q[2];
  assign c_eff = tail ? fb : c;
  assign sys   = c_eff;
  assign {s, par} = rsc_step(c_eff, q);

  // shift the trellis memory on each produced beat
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (step) begin
      q <= {q[1], q[0], s};
    end
  end

endmodule

// File: rtl/turbo_rsc_encoder.sv
// Multi-channel lock-step RSC encoder with
// trellis termination and output register.
module turbo_rsc_encoder
  import turbo_enc_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int KMAX = KMAX_DEF,
  parameter int KMIN = KMIN_DEF,
  parameter int KW   = $clog2(KMAX + 1)
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             start,
  input  logic [KW-1:0]    k_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NCH-1:0]   in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NCH-1:0]   out_sys,
  output logic [NCH-1:0]   out_par,
  output logic             out_tail,
  output logic             out_last,
  output logic             busy,
  output logic             err,
  output logic [3*NCH-1:0] dbg_state
);

  enc_state_e state;
  logic [KW-1:0] klen_r;
  logic [KW-1:0] cnt;
  logic [1:0]    tcnt;

  logic out_free;
  logic data_fire;
  logic tail_fire;
  logic step;
  logic k_ok;
  logic start_ok;
  logic is_tail;
  logic tail_end;

  logic [NCH-1:0] sys_w;
  logic [NCH-1:0] par_w;

  assign out_free  = !out_valid || out_ready;
  assign in_ready  = (state == DATA) && out_free;
  assign data_fire = in_ready && in_valid;
  assign is_tail   = (state == TAIL);
  assign tail_fire = is_tail && out_free;
  assign step      = data_fire || tail_fire;
  assign tail_end  = (tcnt == 2'(TAIL_LEN - 1));
  assign k_ok      = (k_len >= KW'(KMIN))
                  && (k_len <= KW'(KMAX));
  assign start_ok  = start && (state == IDLE)
                  && k_ok;
  assign busy      = (state != IDLE) || out_valid;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [MEM-1:0] q;
    rsc_core u_core (
      .clk   (clk),
      .aclr_n(aclr_n),
      .clr   (start_ok),
      .step  (step),
      .tail  (is_tail),
      .c     (in_bits[g]),
      .sys   (sys_w[g]),
      .par   (par_w[g]),
      .q     (q)
    );
    assign dbg_state[3*g +: 3] = q;
  end

  // block sequencing: data beats, then three tail beats
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state  <= IDLE;
      klen_r <= '0;
      cnt    <= '0;
      tcnt   <= '0;
      err    <= 1'b0;
    end else begin
      err <= start && !start_ok;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            state  <= DATA;
            klen_r <= k_len;
            cnt    <= '0;
          end
        end
        DATA: begin
          if (data_fire) begin
            if (cnt == klen_r - KW'(1)) begin
              state <= TAIL;
              cnt   <= '0;
              tcnt  <= '0;
            end else begin
              cnt <= cnt + KW'(1);
            end
          end
        end
        TAIL: begin
          if (tail_fire) begin
            if (tail_end) begin
              state <= IDLE;
              tcnt  <= '0;
            end else begin
              tcnt <= tcnt + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // single-entry output register, held under backpressure
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      out_valid <= 1'b0;
      out_sys   <= '0;
      out_par   <= '0;
      out_tail  <= 1'b0;
      out_last  <= 1'b0;
    end else if (step) begin
      out_valid <= 1'b1;
      out_sys   <= sys_w;
      out_par   <= par_w;
      out_tail  <= is_tail;
      out_last  <= is_tail && tail_end;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
